// File: rtl/fixpoint_addsub_acc.sv
// Pipelined fixed-point add/subtract/accumulate unit with valid/ready flow control.
// Aligns in1 (QWI1.WF1) and in2 (QWI2.WF2) to a common WS-bit grid, then adds,
// subtracts, accumulates or loads. The result is rounded and saturated (or wrapped)
// to QWIO.WFO. Stage 1 registers the sum or new acc value; stage 2 registers the
// converted output.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   in_valid/in_ready input handshake; in_ready is combinational (!out_valid | out_ready)
//   in1, in2, mode    operands and operation: 00 add, 01 sub, 10 acc += in1, 11 acc = in1
//   out_valid/out_ready output handshake
//   out, ovf          result in QWIO.WFO and its overflow flag
//   ovf_sticky        OR of all presented ovf; clr_sticky clears it and wins over a set
module fixpoint_addsub_acc #(
    parameter int unsigned WI1   = 4,
    parameter int unsigned WF1   = 3,
    parameter int unsigned WI2   = 6,
    parameter int unsigned WF2   = 5,
    parameter int unsigned WIO   = 1,
    parameter int unsigned WFO   = 15,
    parameter int unsigned ACC_G = 4,
    parameter bit          SAT   = 1'b1,
    parameter bit          RND   = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WI1+WF1-1:0]   in1,
    input  logic [WI2+WF2-1:0]   in2,
    input  logic [1:0]           mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIO+WFO-1:0]   out,
    output logic                 ovf,
    output logic                 ovf_sticky,
    input  logic                 clr_sticky
);

    localparam int unsigned INTL    = (WI1 > WI2) ? WI1 : WI2;
    localparam int unsigned FRCL    = (WF1 > WF2) ? WF1 : WF2;
    localparam int unsigned WS      = INTL + ACC_G + FRCL;
    localparam int unsigned WO      = WIO + WFO;
    localparam int unsigned SH1     = FRCL - WF1;
    localparam int unsigned SH2     = FRCL - WF2;
    localparam int unsigned SHL     = (WFO >= FRCL) ? WFO - FRCL : 0;
    localparam int unsigned SHR     = (WFO < FRCL) ? FRCL - WFO : 0;
    localparam int unsigned RND_POS = (SHR > 0) ? SHR - 1 : 0;
    // One spare bit so the rounding increment never wraps.
    localparam int unsigned WE      = WS + SHL + 1;

    logic signed [WS-1:0] a1, a2, res;
    logic signed [WS-1:0] acc_q, acc_d, s1_q, s1_d;
    logic                 s1_valid_q, s1_valid_d;
    logic                 out_valid_q, out_valid_d;
    logic [WO-1:0]        out_q, out_d;
    logic                 ovf_q, ovf_d;
    logic                 sticky_q, sticky_d;
    logic                 advance, accept;

    logic signed [WE-1:0] ext, scaled, upper, rnd_inc;
    logic                 conv_ovf;
    logic [WO-1:0]        conv_out;

    // Operand alignment: sign-extend the integer part, zero-pad the fraction.
    assign a1 = WS'($signed(in1)) <<< SH1;
    assign a2 = WS'($signed(in2)) <<< SH2;

    // Whole pipe moves together whenever the output slot is free or being taken.
    assign advance  = !out_valid_q || out_ready;
    assign accept   = in_valid && advance;
    assign in_ready = advance;

    // Stage 1: arithmetic and accumulator update.
    always_comb begin
        acc_d      = acc_q;
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        unique case (mode)
            2'b00:   res = a1 + a2;
            2'b01:   res = a1 - a2;
            2'b10:   res = acc_q + a1;
            default: res = a1;
        endcase
        if (advance) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_d = res;
                if (mode[1]) begin
                    acc_d = res;
                end
            end
        end
    end

    // Rescale to the output grid; rounding carry is included before the range check.
    assign rnd_inc  = (RND && (SHR > 0)) ? (WE'(1) << RND_POS) : '0;
    assign ext      = WE'(s1_q);
    assign scaled   = ((ext <<< SHL) + rnd_inc) >>> SHR;
    assign upper    = scaled >>> (WO - 1);
    assign conv_ovf = (upper != '0) && (upper != '1);

    always_comb begin
        conv_out = scaled[WO-1:0];
        if (SAT && conv_ovf) begin
            conv_out = scaled[WE-1] ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}};
        end
    end

    // Stage 2: output register and sticky overflow.
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        ovf_d       = ovf_q;
        sticky_d    = sticky_q;
        if (advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d = conv_out;
                ovf_d = conv_ovf;
            end
        end
        if (advance && s1_valid_q && conv_ovf) begin
            sticky_d = 1'b1;
        end
        if (clr_sticky) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q       <= '0;
            s1_q        <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            ovf_q       <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            s1_q        <= s1_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            ovf_q       <= ovf_d;
            sticky_q    <= sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out        = out_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_fixpoint_addsub_acc.sv
// Bench for fixpoint_addsub_acc: default instance plus wrap, round and truncate variants
// driven in parallel and checked against an arithmetic model of the operations.
module tb_fixpoint_addsub_acc;

    localparam int FRCL = 5;
    localparam int WS   = 15;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid, out_ready, clr_sticky;
    logic [6:0]  in1;
    logic [10:0] in2;
    logic [1:0]  mode;

    logic        in_ready, out_valid, ovf, ovf_sticky;
    logic [15:0] out;
    logic        w_in_ready, w_out_valid, w_ovf, w_sticky;
    logic [15:0] w_out;
    logic        r_in_ready, r_out_valid, r_ovf, r_sticky;
    logic [5:0]  r_out;
    logic        t_in_ready, t_out_valid, t_ovf, t_sticky;
    logic [5:0]  t_out;

    always #5 CLK = ~CLK;

    fixpoint_addsub_acc dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
        .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .out(out), .ovf(ovf),
        .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky));

    fixpoint_addsub_acc #(.SAT(1'b0)) dut_wrap (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(w_in_ready), .in1(in1), .in2(in2),
        .mode(mode), .out_valid(w_out_valid), .out_ready(out_ready), .out(w_out), .ovf(w_ovf),
        .ovf_sticky(w_sticky), .clr_sticky(clr_sticky));

    fixpoint_addsub_acc #(.WIO(4), .WFO(2)) dut_rnd (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(r_in_ready), .in1(in1), .in2(in2),
        .mode(mode), .out_valid(r_out_valid), .out_ready(out_ready), .out(r_out), .ovf(r_ovf),
        .ovf_sticky(r_sticky), .clr_sticky(clr_sticky));

    fixpoint_addsub_acc #(.WIO(4), .WFO(2), .RND(1'b0)) dut_trn (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(t_in_ready), .in1(in1), .in2(in2),
        .mode(mode), .out_valid(t_out_valid), .out_ready(out_ready), .out(t_out), .ovf(t_ovf),
        .ovf_sticky(t_sticky), .clr_sticky(clr_sticky));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Value model: numbers are integers in units of 2^-FRCL.
    function automatic longint wrap_ws(input longint v);
        longint m;
        m = v & ((longint'(1) <<< WS) - 1);
        if (m >= (longint'(1) <<< (WS - 1))) m = m - (longint'(1) <<< WS);
        return m;
    endfunction

    function automatic void convert(input longint v, input int wio, input int wfo, input bit sat,
                                    input bit rnd, output longint pat, output bit o);
        longint s, mx, mn;
        int wo;
        wo = wio + wfo;
        if (wfo >= FRCL) begin
            s = v * (longint'(1) <<< (wfo - FRCL));
        end else begin
            s = v;
            if (rnd) s = s + (longint'(1) <<< (FRCL - wfo - 1));
            s = s >>> (FRCL - wfo);
        end
        mx = (longint'(1) <<< (wo - 1)) - 1;
        mn = -(longint'(1) <<< (wo - 1));
        o = (s > mx) || (s < mn);
        if (o && sat) s = (s > mx) ? mx : mn;
        pat = s & ((longint'(1) <<< wo) - 1);
    endfunction

    typedef struct {
        longint v;
        int     id;
    } item_t;

    item_t  exp_q[$];
    item_t  pend;
    longint acc_m = 0;
    bit     sticky_m = 0;
    int     next_id = 0;
    int     last_id = -1;
    bit     mon_en = 0;
    bit     rst_p = 0, xfer_p = 0, acc_p = 0, clr_p = 0;
    longint cap_out[$], cap_ovf[$], cap_w[$], cap_wovf[$], cap_r[$], cap_t[$];
    longint p, a1, a2, v;
    bit     o;

    // Model update, per-cycle comparison, then sampling of this cycle's handshakes.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (rst_p) begin
                exp_q.delete();
                acc_m    = 0;
                sticky_m = 0;
            end else begin
                if (xfer_p && exp_q.size() > 0) void'(exp_q.pop_front());
                if (acc_p) exp_q.push_back(pend);
                if (clr_p) sticky_m = 0;
                if (out_valid && exp_q.size() > 0 && exp_q[0].id != last_id) begin
                    last_id = exp_q[0].id;
                    convert(exp_q[0].v, 1, 15, 1'b1, 1'b1, p, o);
                    if (o && !clr_p) sticky_m = 1;
                end
            end

            check("in_ready_rule", in_ready, !out_valid || out_ready);
            check("aux_flow", {w_out_valid, r_out_valid, t_out_valid, w_in_ready, r_in_ready, t_in_ready},
                  {{3{out_valid}}, {3{in_ready}}});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out_valid: got out_valid=1, expected 0 (t=%0t)", $time);
                end else begin
                    convert(exp_q[0].v, 1, 15, 1'b1, 1'b1, p, o);
                    check("out", out, p);
                    check("ovf", ovf, o);
                    convert(exp_q[0].v, 1, 15, 1'b0, 1'b1, p, o);
                    check("wrap_out", w_out, p);
                    check("wrap_ovf", w_ovf, o);
                    convert(exp_q[0].v, 4, 2, 1'b1, 1'b1, p, o);
                    check("rnd_out", r_out, p);
                    check("rnd_ovf", r_ovf, o);
                    convert(exp_q[0].v, 4, 2, 1'b1, 1'b0, p, o);
                    check("trn_out", t_out, p);
                    check("trn_ovf", t_ovf, o);
                end
            end
            check("ovf_sticky", ovf_sticky, sticky_m);

            rst_p  = RST;
            clr_p  = clr_sticky;
            xfer_p = !RST && out_valid && out_ready;
            if (xfer_p) begin
                cap_out.push_back(out);
                cap_ovf.push_back(ovf);
                cap_w.push_back(w_out);
                cap_wovf.push_back(w_ovf);
                cap_r.push_back(r_out);
                cap_t.push_back(t_out);
            end
            acc_p = !RST && in_valid && in_ready;
            if (acc_p) begin
                a1 = longint'($signed(in1)) * 4;
                a2 = longint'($signed(in2));
                case (mode)
                    2'd0: v = a1 + a2;
                    2'd1: v = a1 - a2;
                    2'd2: begin acc_m = wrap_ws(acc_m + a1); v = acc_m; end
                    default: begin acc_m = wrap_ws(a1); v = acc_m; end
                endcase
                pend.v  = wrap_ws(v);
                pend.id = next_id;
                next_id++;
            end
        end
    end

    task automatic clear_caps();
        cap_out.delete(); cap_ovf.delete(); cap_w.delete();
        cap_wovf.delete(); cap_r.delete(); cap_t.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Presents one sample for one cycle; assumes out_ready=1 so it is accepted.
    task automatic send(input logic [6:0] a, input logic [10:0] b, input logic [1:0] m);
        in1 = a; in2 = b; mode = m; in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    logic [6:0] bp_in1 [5];
    logic [1:0] bp_mode[5];
    int         idx, stalls;
    bit         acc_ok;

    initial begin
        RST = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
        in1 = '0; in2 = '0; mode = '0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_ovf", ovf, 0);
        check("rst_sticky", ovf_sticky, 0);
        check("rst_in_ready", in_ready, 1);
        mon_en = 1'b1;

        // Add with 2-cycle latency.
        send(7'h02, 11'h010, 2'b00);
        check("t1_not_early", out_valid, 0);
        @(posedge CLK);
        #1;
        check("t1_valid", out_valid, 1);
        check("t1_out", out, 16'h6000);
        check("t1_ovf", ovf, 0);
        idle(3);

        // Saturate vs wrap, then sticky clear.
        clear_caps();
        send(7'h08, 11'h010, 2'b00);
        idle(3);
        check("t2_count", cap_out.size(), 1);
        if (cap_out.size() >= 1) begin
            check("t2_sat_out", cap_out[0], 16'h7FFF);
            check("t2_sat_ovf", cap_ovf[0], 1);
            check("t2_wrap_out", cap_w[0], 16'hC000);
            check("t2_wrap_ovf", cap_wovf[0], 1);
        end
        check("t2_sticky", ovf_sticky, 1);
        clr_sticky = 1'b1;
        idle(1);
        clr_sticky = 1'b0;
        check("t2_sticky_clr", ovf_sticky, 0);

        // Subtract.
        clear_caps();
        send(7'h7C, 11'h010, 2'b01);
        idle(3);
        check("t3_sub_count", cap_out.size(), 1);
        if (cap_out.size() >= 1) begin
            check("t3_sub_out", cap_out[0], 16'h8000);
            check("t3_sub_ovf", cap_ovf[0], 0);
        end

        // Load then accumulate up to overflow.
        clear_caps();
        send(7'h01, 11'h000, 2'b11);
        for (int i = 0; i < 7; i++) send(7'h01, 11'h000, 2'b10);
        idle(4);
        check("t3_acc_count", cap_out.size(), 8);
        for (int i = 0; i < 7 && i < cap_out.size(); i++) begin
            check("t3_acc_out", cap_out[i], 16'h1000 * (i + 1));
            check("t3_acc_ovf", cap_ovf[i], 0);
        end
        if (cap_out.size() >= 8) begin
            check("t3_acc_sat", cap_out[7], 16'h7FFF);
            check("t3_acc_sat_ovf", cap_ovf[7], 1);
        end
        check("t3_sticky", ovf_sticky, 1);

        // Rounding vs truncation at Q4.2.
        clear_caps();
        send(7'h01, 11'h000, 2'b00);
        idle(3);
        check("t4_count", cap_r.size(), 1);
        if (cap_r.size() >= 1) begin
            check("t4_rnd", cap_r[0], 6'h01);
            check("t4_trn", cap_t[0], 6'h00);
        end

        // Back-pressure mid-stream.
        bp_in1  = '{7'h02, 7'h02, 7'h02, 7'h7F, 7'h7F};
        bp_mode = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10};
        clear_caps();
        idx = 0;
        stalls = 0;
        for (int c = 0; c < 40 && idx < 5; c++) begin
            out_ready = !(c >= 2 && c <= 4);
            in_valid  = 1'b1;
            in1 = bp_in1[idx]; in2 = '0; mode = bp_mode[idx];
            @(negedge CLK);
            if (out_valid && !out_ready) begin
                stalls++;
                check("t5_in_ready_low", in_ready, 0);
            end
            acc_ok = in_valid && in_ready;
            @(posedge CLK);
            #1;
            if (acc_ok) idx++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(5);
        check("t5_accepted", idx, 5);
        check("t5_stalled", stalls, 3);
        check("t5_count", cap_out.size(), 5);
        if (cap_out.size() >= 5) begin
            check("t5_out0", cap_out[0], 16'h2000);
            check("t5_out1", cap_out[1], 16'h4000);
            check("t5_out2", cap_out[2], 16'h6000);
            check("t5_out3", cap_out[3], 16'h5000);
            check("t5_out4", cap_out[4], 16'h4000);
        end

        // Reset mid-accumulation.
        send(7'h01, 11'h000, 2'b11);
        send(7'h01, 11'h000, 2'b10);
        send(7'h01, 11'h000, 2'b10);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("t6_out_valid", out_valid, 0);
        check("t6_sticky", ovf_sticky, 0);
        check("t6_in_ready", in_ready, 1);
        clear_caps();
        send(7'h01, 11'h000, 2'b11);
        send(7'h01, 11'h000, 2'b10);
        idle(4);
        check("t6_count", cap_out.size(), 2);
        if (cap_out.size() >= 2) begin
            check("t6_out0", cap_out[0], 16'h1000);
            check("t6_out1", cap_out[1], 16'h2000);
        end

        // Randomized traffic with stalls, sticky clears and occasional reset.
        for (int c = 0; c < 2000; c++) begin
            in_valid   = ($urandom_range(3) != 0);
            in1        = 7'($urandom);
            in2        = 11'($urandom);
            mode       = 2'($urandom);
            out_ready  = ($urandom_range(9) < 7);
            clr_sticky = ($urandom_range(39) == 0);
            RST        = ($urandom_range(149) == 0);
            @(posedge CLK);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0; RST = 1'b0;
        idle(6);
        check("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
